// File: rtl/bar_recorder_pkg.sv
// Shared tracker definitions: note code layout, rest value and recorder states.
// The song player decodes note codes with the same field positions.
package bar_recorder_pkg;

    localparam logic [7:0] NOTE_REST  = 8'h00;
    localparam int         NOTE_HI    = 7;
    localparam int         NOTE_LO    = 4;
    localparam int         OCT_HI     = 3;
    localparam int         OCT_LO     = 0;
    localparam int         NOTE_MAX   = 12;
    localparam int         OCTAVE_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT_IN,
        ST_RECORD,
        ST_DONE
    } rec_state_e;

    // A playable code has note 1..12 (C..B) and octave 0..6.
    function automatic logic note_ok(input logic [7:0] code);
        logic [3:0] n;
        logic [3:0] o;
        n = code[NOTE_HI:NOTE_LO];
        o = code[OCT_HI:OCT_LO];
        return (n >= 4'd1) && (n <= 4'(NOTE_MAX)) && (o <= 4'(OCTAVE_MAX));
    endfunction

endpackage

// File: rtl/bar_recorder_if.sv
// Control, note input and bar-RAM write bus of the bar recorder.
// master drives start/ticks/notes, slave is the recorder.
interface bar_recorder_if #(
    parameter int BAR_IDX_BITS = 3
) ();
    logic                    tick_en;
    logic                    start;
    logic [BAR_IDX_BITS-1:0] bar_sel;
    logic                    note_valid;
    logic [7:0]              note_in;
    logic                    wr_en;
    logic [BAR_IDX_BITS+3:0] wr_addr;
    logic [7:0]              wr_data;
    logic                    click;
    logic                    busy;
    logic                    done;
    logic [3:0]              row_pos;

    modport master (
        output tick_en, start, bar_sel, note_valid, note_in,
        input  wr_en, wr_addr, wr_data, click, busy, done, row_pos
    );

    modport slave (
        input  tick_en, start, bar_sel, note_valid, note_in,
        output wr_en, wr_addr, wr_data, click, busy, done, row_pos
    );
endinterface

// File: rtl/bar_recorder_tick_row_counter.sv
// Tick-within-row and row counters driven by a tick strobe; shared with the
// song player. Row events are combinational on tick_en so callers can register them.
module tick_row_counter #(
    parameter int TICKS_PER_ROW = 8,
    parameter int ROW_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             clr,
    output logic             row_start,
    output logic             row_end,
    output logic             late_half,
    output logic [ROW_W-1:0] row
);
    localparam int            TW        = $clog2(TICKS_PER_ROW);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_ROW - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_ROW / 2);

    logic [TW-1:0]    tick_q, tick_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign row_start = tick_en && (tick_q == '0);
    assign row_end   = tick_en && (tick_q == TICK_LAST);
    assign late_half = (tick_q >= TICK_HALF);
    assign row       = row_q;

    always_comb begin
        tick_d = tick_q;
        row_d  = row_q;
        if (clr) begin
            tick_d = '0;
            row_d  = '0;
        end else if (tick_en) begin
            tick_d = row_end ? '0 : tick_q + 1'b1;
            if (row_end)
                row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            row_q  <= '0;
        end else begin
            tick_q <= tick_d;
            row_q  <= row_d;
        end
    end
endmodule

// File: rtl/bar_recorder.sv
// Live bar capture: count-in with click, then quantize notes onto rows and
// write one note code (or rest) per row into the external bar RAM.
module bar_recorder
    import bar_recorder_pkg::*;
#(
    parameter int NUM_ROWS_PER_BAR = 16,
    parameter int TICKS_PER_ROW    = 8,
    parameter int COUNT_IN_ROWS    = 4,
    parameter int BAR_IDX_BITS     = 3
) (
    input  logic          main_clk,
    input  logic          rst,
    bar_recorder_if.slave bus
);
    localparam int AW = BAR_IDX_BITS + 4;

    rec_state_e              state_q, state_d;
    logic [BAR_IDX_BITS-1:0] bar_q, bar_d;
    logic [7:0]              cur_q, cur_d;
    logic [7:0]              next_q, next_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    click_q, click_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [3:0]              row_pos_q, row_pos_d;

    logic       cnt_clr;
    logic       row_start, row_end, late_half;
    logic [3:0] row;
    logic       note_acc;

    tick_row_counter #(
        .TICKS_PER_ROW(TICKS_PER_ROW),
        .ROW_W        (4)
    ) u_cnt (
        .clk      (main_clk),
        .rst      (rst),
        .tick_en  (bus.tick_en),
        .clr      (cnt_clr),
        .row_start(row_start),
        .row_end  (row_end),
        .late_half(late_half),
        .row      (row)
    );

    always_comb begin
        state_d   = state_q;
        bar_d     = bar_q;
        cur_d     = cur_q;
        next_d    = next_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        click_d   = 1'b0;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        row_pos_d = row;
        note_acc  = bus.note_valid && note_ok(bus.note_in);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bar_d   = bus.bar_sel;
                    cur_d   = NOTE_REST;
                    next_d  = NOTE_REST;
                    cnt_clr = 1'b1;
                    state_d = ST_COUNT_IN;
                end
            end
            ST_COUNT_IN: begin
                click_d = row_start;
                // Only late notes count here: they belong to record row 0.
                if (note_acc && late_half)
                    next_d = bus.note_in;
                if (row_end) begin
                    cur_d  = next_d;
                    next_d = NOTE_REST;
                    if (row == 4'(COUNT_IN_ROWS - 1)) begin
                        cnt_clr = 1'b1;
                        state_d = ST_RECORD;
                    end
                end
            end
            ST_RECORD: begin
                click_d = row_start;
                if (note_acc) begin
                    if (late_half)
                        next_d = bus.note_in;
                    else
                        cur_d = bus.note_in;
                end
                // A note on the row-ending tick is late, so it already sits in next_d.
                if (row_end) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {bar_q, row};
                    wr_data_d = cur_q;
                    cur_d     = next_d;
                    next_d    = NOTE_REST;
                    if (row == 4'(NUM_ROWS_PER_BAR - 1)) begin
                        cur_d   = NOTE_REST;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bar_q     <= '0;
            cur_q     <= NOTE_REST;
            next_q    <= NOTE_REST;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            click_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            row_pos_q <= '0;
        end else begin
            state_q   <= state_d;
            bar_q     <= bar_d;
            cur_q     <= cur_d;
            next_q    <= next_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            click_q   <= click_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            row_pos_q <= row_pos_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.click   = click_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.row_pos = row_pos_q;
endmodule

// File: tb/tb_bar_recorder.sv
// Directed bench for bar_recorder: empty bar, quantization, boundary notes,
// start-while-busy, mid-bar reset and restart.
module tb_bar_recorder;
    logic main_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 main_clk = ~main_clk;

    bar_recorder_if #(.BAR_IDX_BITS(3)) bus ();

    bar_recorder #(
        .NUM_ROWS_PER_BAR(16),
        .TICKS_PER_ROW   (8),
        .COUNT_IN_ROWS   (4),
        .BAR_IDX_BITS    (3)
    ) dut (
        .main_clk(main_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write log and pulse counters sampled mid-cycle.
    logic [6:0] wa_log[$];
    logic [7:0] wd_log[$];
    int         clk_cnt  = 0;
    int         done_cnt = 0;

    always @(negedge main_clk) begin
        if (bus.wr_en) begin
            wa_log.push_back(bus.wr_addr);
            wd_log.push_back(bus.wr_data);
        end
        if (bus.click) clk_cnt++;
        if (bus.done)  done_cnt++;
    end

    // One tick: a gap cycle (counter shows tick g%8) then the tick_en cycle.
    task automatic step(input int g, input bit notes);
        logic       gv, cv;
        logic [7:0] gd, cd;
        gv = 1'b0; gd = 8'h00; cv = 1'b0; cd = 8'h00;
        if (notes) begin
            case (g)
                31:  begin gv = 1'b1; gd = 8'h93; end
                49:  begin gv = 1'b1; gd = 8'hD4; end
                50:  begin gv = 1'b1; gd = 8'h17; end
                57:  begin gv = 1'b1; gd = 8'h24; end
                58:  begin gv = 1'b1; gd = 8'h35; end
                74:  begin gv = 1'b1; gd = 8'h15; end
                94:  begin gv = 1'b1; gd = 8'hA4; end
                111: begin cv = 1'b1; cd = 8'h62; end
                157: begin gv = 1'b1; gd = 8'hC6; end
                default: ;
            endcase
        end
        bus.note_valid = gv;
        bus.note_in    = gd;
        @(negedge main_clk);
        bus.tick_en    = 1'b1;
        bus.note_valid = cv;
        bus.note_in    = cd;
        @(negedge main_clk);
        bus.tick_en    = 1'b0;
        bus.note_valid = 1'b0;
    endtask

    task automatic start_bar(input logic [2:0] b);
        bus.bar_sel = b;
        bus.start   = 1'b1;
        @(negedge main_clk);
        bus.start   = 1'b0;
    endtask

    function automatic logic [7:0] exp_row(input bit notes, input int i);
        if (!notes) return 8'h00;
        case (i)
            0:       return 8'h93;
            3:       return 8'h35;
            5:       return 8'h15;
            8:       return 8'hA4;
            10:      return 8'h62;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_bar(input string tag, input int base, input logic [2:0] b, input bit notes);
        chk({tag, "_nwr"}, wa_log.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wa_log.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wa_log[base+i], {b, 4'(i)});
                chk($sformatf("%s_data%0d", tag, i), wd_log[base+i], exp_row(notes, i));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base, c0, c1, d0;
        bus.tick_en = 1'b0; bus.start = 1'b0; bus.bar_sel = 3'd0;
        bus.note_valid = 1'b0; bus.note_in = 8'h00;
        repeat (3) @(negedge main_clk);
        chk("rst_wr_en",   bus.wr_en,   0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_click",   bus.click,   0);
        chk("rst_busy",    bus.busy,    0);
        chk("rst_done",    bus.done,    0);
        chk("rst_row_pos", bus.row_pos, 0);
        rst = 1'b0;
        @(negedge main_clk);

        // Empty bar into bar 3.
        base = wa_log.size(); c0 = clk_cnt; d0 = done_cnt; c1 = 0;
        start_bar(3'd3);
        chk("e_busy_rise", bus.busy, 1);
        for (int g = 0; g < 160; g++) begin
            step(g, 1'b0);
            if (g == 31) c1 = clk_cnt;
        end
        repeat (4) @(negedge main_clk);
        chk("e_click_cnt_in", c1 - c0, 4);
        chk("e_click_rec", clk_cnt - c1, 16);
        chk("e_done_cnt", done_cnt - d0, 1);
        chk("e_busy_end", bus.busy, 0);
        check_bar("e", base, 3'd3, 1'b0);

        // Noted bar into bar 1, with a start (bar 5) mid-record that must be ignored.
        base = wa_log.size(); d0 = done_cnt;
        start_bar(3'd1);
        for (int g = 0; g < 160; g++) begin
            if (g == 80) begin bus.start = 1'b1; bus.bar_sel = 3'd5; end
            step(g, 1'b1);
            bus.start = 1'b0;
            if (g == 20) chk("n_row_pos_ci", bus.row_pos, 2);
            if (g == 85) chk("n_row_pos_rec", bus.row_pos, 6);
            if (g == 100) chk("n_busy_mid", bus.busy, 1);
        end
        repeat (4) @(negedge main_clk);
        chk("n_done_cnt", done_cnt - d0, 1);
        check_bar("n", base, 3'd1, 1'b1);

        // Reset during record row 6 of bar 2.
        base = wa_log.size();
        start_bar(3'd2);
        for (int g = 0; g < 83; g++) step(g, 1'b0);
        #2 rst = 1'b1;
        #1 chk("r_busy_async", bus.busy, 0);
        chk("r_wr_en_async", bus.wr_en, 0);
        @(negedge main_clk);
        rst = 1'b0;
        for (int g = 0; g < 40; g++) step(g, 1'b0);
        chk("r_nwr", wa_log.size() - base, 6);
        if (wa_log.size() > base + 5) begin
            chk("r_addr0", wa_log[base], 7'h20);
            chk("r_addr5", wa_log[base+5], 7'h25);
        end

        // Fresh full bar into bar 4 after the reset.
        base = wa_log.size(); d0 = done_cnt;
        start_bar(3'd4);
        for (int g = 0; g < 160; g++) step(g, 1'b0);
        repeat (4) @(negedge main_clk);
        chk("f_done_cnt", done_cnt - d0, 1);
        check_bar("f", base, 3'd4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
